// File: rtl/ctrl_fsm_gen.sv
// ctrl_fsm_gen: control sequencer for the microcore (fetch/decode/execute/write-back).
// It steps through each instruction using per-unit ack handshakes. A watchdog
// moves the core to ERR if a unit never acks, and single-step mode can pause it
// after each instruction.
// Optional build macro PERF_CNT_EN: adds a retired-instruction counter on instr_cnt.
// Without the macro, instr_cnt is tied to 0.
module ctrl_fsm_gen #(
    parameter int OPC_W = 3,
    parameter int TMO_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opc_in,
    input  logic             zero_flag,
    input  logic             ri_ack,
    input  logic             pc_ack,
    input  logic             ula_ack,
    input  logic             wr_ack,
    input  logic             step_mode,
    input  logic             step_go,
    output logic             ena_pc,
    output logic             ena_ri,
    output logic             ena_wr,
    output logic             ena_ula,
    output logic             sel_r0_rd,
    output logic             sel_addr_data,
    output logic             sel_ldr_ula,
    output logic             ld_pc,
    output logic             halted,
    output logic             err_tmo,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_PC     = 4'd0,
        S_FETCH  = 4'd1,
        S_LDR    = 4'd2,
        S_ARIT   = 4'd3,
        S_WB_RD  = 4'd4,
        S_LOGIC  = 4'd5,
        S_WB_R0  = 4'd6,
        S_BRANCH = 4'd7,
        S_HALT   = 4'd8,
        S_ERR    = 4'd9,
        S_STEP   = 4'd10
    } state_e;

    localparam logic [TMO_W-1:0] WDOG_MAX = '1;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] wdog_q, wdog_d;
    logic             err_q;
    logic             waiting;
    logic             ack_ok;
    logic             opc_hi_nz;

    // Opcodes wider than 3 bits are legal only while the extra bits are zero.
    generate
        if (OPC_W > 3) begin : g_opc_hi
            assign opc_hi_nz = |opc_in[OPC_W-1:3];
        end else begin : g_opc_no_hi
            assign opc_hi_nz = 1'b0;
        end
    endgenerate

    // Find out whether the current state is waiting on a unit, and whether that unit's ack is here.
    always_comb begin
        waiting = 1'b1;
        ack_ok  = 1'b0;
        case (state_q)
            S_FETCH:           ack_ok = ri_ack;
            S_PC, S_BRANCH:    ack_ok = pc_ack;
            S_LDR, S_WB_RD,
            S_WB_R0:           ack_ok = wr_ack;
            S_ARIT, S_LOGIC:   ack_ok = ula_ack;
            default:           waiting = 1'b0;
        endcase
    end

    // Next state: an ack advances the FSM, otherwise a watchdog timeout moves to ERR.
    // If an ack arrives in the same cycle as the timeout, the ack wins.
    always_comb begin
        state_d = state_q;
        if (state_q == S_STEP) begin
            if (step_go) state_d = S_FETCH;
        end else if (waiting && ack_ok) begin
            case (state_q)
                S_FETCH: begin
                    if (opc_hi_nz) begin
                        state_d = S_ERR;
                    end else begin
                        case (opc_in[2:0])
                            3'b000:         state_d = S_LDR;
                            3'b001:         state_d = S_LOGIC;
                            3'b010, 3'b011: state_d = S_ARIT;
                            3'b100:         state_d = zero_flag ? S_BRANCH : S_PC;
                            3'b101:         state_d = S_BRANCH;
                            3'b110:         state_d = S_PC;
                            default:        state_d = S_HALT;
                        endcase
                    end
                end
                S_PC, S_BRANCH:  state_d = step_mode ? S_STEP : S_FETCH;
                S_LDR:           state_d = S_PC;
                S_ARIT:          state_d = S_WB_RD;
                S_LOGIC:         state_d = S_WB_R0;
                S_WB_RD, S_WB_R0: state_d = S_PC;
                default:         state_d = state_q;
            endcase
        end else if (waiting && (wdog_q == WDOG_MAX)) begin
            state_d = S_ERR;
        end
    end

    // Watchdog next value: count wait cycles in the current state, restart at
    // every state change, and saturate at the maximum instead of wrapping.
    always_comb begin
        wdog_d = wdog_q;
        if ((state_d != state_q) || !waiting) begin
            wdog_d = '0;
        end else if (wdog_q != WDOG_MAX) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    // State, watchdog and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            if (state_d == S_ERR) err_q <= 1'b1;
        end
    end

    // Moore outputs, decoded from the current state only.
    always_comb begin
        ena_pc        = 1'b0;
        ena_ri        = 1'b0;
        ena_wr        = 1'b0;
        ena_ula       = 1'b0;
        sel_r0_rd     = 1'b0;
        sel_addr_data = 1'b0;
        sel_ldr_ula   = 1'b0;
        ld_pc         = 1'b0;
        halted        = 1'b0;
        case (state_q)
            S_PC:    ena_pc = 1'b1;
            S_FETCH: ena_ri = 1'b1;
            S_LDR: begin
                ena_wr      = 1'b1;
                sel_r0_rd   = 1'b1;
                sel_ldr_ula = 1'b1;
            end
            S_ARIT, S_LOGIC: begin
                ena_ula       = 1'b1;
                sel_addr_data = 1'b1;
            end
            S_WB_RD: begin
                ena_wr    = 1'b1;
                sel_r0_rd = 1'b1;
            end
            S_WB_R0: ena_wr = 1'b1;
            S_BRANCH: begin
                ena_pc = 1'b1;
                ld_pc  = 1'b1;
            end
            S_HALT, S_ERR: halted = 1'b1;
            default: ;
        endcase
    end

    assign err_tmo   = err_q;
    assign state_out = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    assign retire = ((state_q == S_PC) || (state_q == S_BRANCH)) && pc_ack;

    // An instruction retires when the PC update is acknowledged; the count wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + 1'b1;
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_fsm_gen.sv
// Randomized scoreboard bench for ctrl_fsm_gen. The reference model treats each
// decoded instruction as a plan of unit steps, and each step waits for the ack of its unit.
module tb_ctrl_fsm_gen;

    localparam int OPC_W = 4;
    localparam int TMO_W = 4;
    localparam int CNT_W = 2;
    localparam int TMAX  = (1 << TMO_W) - 1;
    localparam int NCYC  = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic [OPC_W-1:0] opc_in;
    logic             zero_flag, ri_ack, pc_ack, ula_ack, wr_ack, step_mode, step_go;
    logic             ena_pc, ena_ri, ena_wr, ena_ula, sel_r0_rd, sel_addr_data, sel_ldr_ula;
    logic             ld_pc, halted, err_tmo;
    logic [3:0]       state_out;
    logic [CNT_W-1:0] instr_cnt;

    always #5 clk = ~clk;

    ctrl_fsm_gen #(.OPC_W(OPC_W), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opc_in(opc_in), .zero_flag(zero_flag),
        .ri_ack(ri_ack), .pc_ack(pc_ack), .ula_ack(ula_ack), .wr_ack(wr_ack),
        .step_mode(step_mode), .step_go(step_go),
        .ena_pc(ena_pc), .ena_ri(ena_ri), .ena_wr(ena_wr), .ena_ula(ena_ula),
        .sel_r0_rd(sel_r0_rd), .sel_addr_data(sel_addr_data), .sel_ldr_ula(sel_ldr_ula),
        .ld_pc(ld_pc), .halted(halted), .err_tmo(err_tmo),
        .state_out(state_out), .instr_cnt(instr_cnt)
    );

    typedef struct {
        int st;
        int outs;
        int err;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Model state: current step code, wait count, remaining plan, error and retire count.
    int   cur  = 1;
    int   wc   = 0;
    int   plan[$];
    int   merr = 0;
    int   mcnt = 0;

    // Output table, bit order {ena_pc,ena_ri,ena_wr,ena_ula,sel_r0_rd,sel_addr_data,sel_ldr_ula,ld_pc,halted}.
    function automatic int outs_of(int code);
        case (code)
            0:       return 'b100000000;
            1:       return 'b010000000;
            2:       return 'b001010100;
            3, 5:    return 'b000101000;
            4:       return 'b001010000;
            6:       return 'b001000000;
            7:       return 'b100000010;
            8, 9:    return 'b000000001;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    endtask

    // Monitor: on each falling edge, pop one expectation and compare it with the DUT.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                exp_t e;
                int   o;
                e = q.pop_front();
                o = {ena_pc, ena_ri, ena_wr, ena_ula, sel_r0_rd, sel_addr_data,
                     sel_ldr_ula, ld_pc, halted};
                chk("state_out", int'(state_out), e.st);
                chk("outputs", o, e.outs);
                chk("err_tmo", int'(err_tmo), e.err);
                chk("instr_cnt", int'(instr_cnt), e.cnt);
            end
        end
    end

    // Advance the model by one clock edge using the inputs driven this cycle.
    task automatic model_step();
        int ack;
        if (cur == 8 || cur == 9) return;
        if (cur == 10) begin
            if (step_go) cur = 1;
            return;
        end
        case (cur)
            1:       ack = ri_ack;
            0, 7:    ack = pc_ack;
            3, 5:    ack = ula_ack;
            default: ack = wr_ack;
        endcase
        if (ack != 0) begin
            wc = 0;
            if (cur == 1) begin
                plan.delete();
                if (opc_in[3]) plan.push_back(9);
                else case (opc_in[2:0])
                    3'd0: begin plan.push_back(2); plan.push_back(0); end
                    3'd1: begin plan.push_back(5); plan.push_back(6); plan.push_back(0); end
                    3'd2, 3'd3: begin plan.push_back(3); plan.push_back(4); plan.push_back(0); end
                    3'd4: plan.push_back(zero_flag ? 7 : 0);
                    3'd5: plan.push_back(7);
                    3'd6: plan.push_back(0);
                    default: plan.push_back(8);
                endcase
                cur = plan.pop_front();
            end else if (cur == 0 || cur == 7) begin
`ifdef PERF_CNT_EN
                mcnt = (mcnt + 1) % (1 << CNT_W);
`endif
                cur = step_mode ? 10 : 1;
            end else begin
                cur = plan.pop_front();
            end
        end else if (wc == TMAX) begin
            cur = 9;
            wc  = 0;
        end else begin
            wc++;
        end
        if (cur == 9) merr = 1;
    endtask

    // Driver: choose random inputs just after each rising edge, queue the
    // expectation for this cycle, then advance the model.
    initial begin
        int term = 0;
        int p;
        rst = 1'b0; opc_in = '0; zero_flag = 1'b0; ri_ack = 1'b0; pc_ack = 1'b0;
        ula_ack = 1'b0; wr_ack = 1'b0; step_mode = 1'b0; step_go = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            // Long stretches with rare acks exercise the watchdog path.
            p = ((cyc / 500) % 3 == 2) ? 4 : 50;
            if (wc == TMAX) p = 50;
            if (cur == 8 || cur == 9) term++;
            else term = 0;
            rst       = !(cyc < 2 || term >= 4 || $urandom_range(0, 399) == 0);
            ri_ack    = ($urandom_range(0, 99) < p);
            pc_ack    = ($urandom_range(0, 99) < p);
            ula_ack   = ($urandom_range(0, 99) < p);
            wr_ack    = ($urandom_range(0, 99) < p);
            zero_flag = $urandom_range(0, 1) == 1;
            step_go   = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 99) == 0) step_mode = ~step_mode;
            p = $urandom_range(0, 99);
            if (p < 4) opc_in = {1'b1, 3'($urandom_range(0, 7))};
            else if (p < 8) opc_in = 4'd7;
            else opc_in = {1'b0, 3'($urandom_range(0, 6))};
            if (!rst) begin
                cur = 1; wc = 0; merr = 0; mcnt = 0; plan.delete();
            end
            q.push_back('{st: cur, outs: outs_of(cur), err: merr, cnt: mcnt});
            if (rst) model_step();
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
